// File: rtl/audio_rec_pkg.sv
// rtl/audio_rec_pkg.sv - shared state encoding and sample-divider helper for audio_recorder
package audio_rec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2,
    DONE   = 2'd3
  } rec_state_t;

  localparam int MIN_DIV = 2;

  function automatic int calc_div(input int clk_hz, input int sample_rate);
    return clk_hz / sample_rate;
  endfunction

  function automatic bit div_ok(input int div);
    return div >= MIN_DIV;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - frame-rate strobe, high on the last cycle of each DIV-cycle period
module sample_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign tick   = en && w_wrap;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/audio_recorder.sv
// rtl/audio_recorder.sv - mic record/playback engine with divided-rate capture RAM
// Optional LOOP_PLAY_EN: playback wraps to frame 0 and only leaves PLAY on stop.
module audio_recorder
  import audio_rec_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int SAMPLE_RATE = 48000,
  parameter int DATA_W      = 16,
  parameter int CHANNELS    = 1,
  parameter int DEPTH       = 96000,
  parameter int LED_W       = 18
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS*DATA_W-1:0]    mic_in,
  input  logic                          rec_start,
  input  logic                          play_start,
  input  logic                          stop,
  output logic [CHANNELS*DATA_W-1:0]    audio_out,
  output logic                          audio_valid,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(DEPTH):0]        rec_len,
  output logic [LED_W-1:0]              ledr
);

  localparam int FW  = CHANNELS * DATA_W;
  localparam int AW  = $clog2(DEPTH);
  localparam int DIV = calc_div(CLK_HZ, SAMPLE_RATE);
  localparam int PW  = LED_W - 3;
  localparam int LSH = (AW > PW) ? AW - PW : 0;

  if (!div_ok(DIV)) begin : g_bad_div
    $error("audio_recorder: CLK_HZ/SAMPLE_RATE must be at least 2");
  end
  if (LED_W < 4) begin : g_bad_led
    $error("audio_recorder: LED_W must be at least 4");
  end

  rec_state_t    r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_rec_len;
  logic [FW-1:0] r_audio_out;
  logic          r_audio_valid;
  logic          r_busy;
  logic          r_done;
  logic          r_play_end;
  logic [LED_W-1:0] r_ledr;
  logic [FW-1:0] r_mem [DEPTH];

  logic          w_en;
  logic          w_tick;
  logic          w_rd_last;
  logic [AW-1:0] w_ptr;
  logic [PW-1:0] w_ptr_led;

  assign w_en      = (r_state == RECORD) || (r_state == PLAY);
  assign w_rd_last = ({1'b0, r_rd_ptr} == (r_rec_len - 1'b1));
  assign w_ptr     = (r_state == RECORD) ? r_wr_ptr :
                     (r_state == PLAY)   ? r_rd_ptr : '0;
  assign w_ptr_led = PW'(w_ptr >> LSH);

  sample_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (w_en),
    .clr  (!w_en),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst && r_state == RECORD && w_tick) begin
      r_mem[r_wr_ptr] <= mic_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_rec_len     <= '0;
      r_audio_out   <= '0;
      r_audio_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_play_end    <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_audio_valid <= 1'b0;
      if (r_state != PLAY) begin
        r_audio_out <= mic_in;
      end
      case (r_state)
        IDLE: begin
          if (rec_start) begin
            r_state   <= RECORD;
            r_wr_ptr  <= '0;
            r_rec_len <= '0;
            r_busy    <= 1'b1;
          end else if (play_start && r_rec_len != '0) begin
            r_state    <= PLAY;
            r_rd_ptr   <= '0;
            r_play_end <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RECORD: begin
          if (w_tick) begin
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_rec_len <= {1'b0, r_wr_ptr} + 1'b1;
          end
          if (stop || (w_tick && r_wr_ptr == AW'(DEPTH - 1))) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        PLAY: begin
          // The output register doubles as the RAM read port, so a frame lands one clock after its tick.
          if (w_tick) begin
            r_audio_out   <= r_mem[r_rd_ptr];
            r_audio_valid <= 1'b1;
`ifdef LOOP_PLAY_EN
            r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + 1'b1;
`else
            r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_rd_last) begin
              r_play_end <= 1'b1;
            end
`endif
          end
          if (stop || r_play_end) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ledr <= '0;
    end else begin
      r_ledr <= {w_ptr_led, (r_rec_len == (AW + 1)'(DEPTH)), (r_state == PLAY), (r_state == RECORD)};
    end
  end

  assign audio_out   = r_audio_out;
  assign audio_valid = r_audio_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign rec_len     = r_rec_len;
  assign ledr        = r_ledr;

endmodule

// File: tb/tb_audio_recorder.sv
// tb/tb_audio_recorder.sv - scoreboard bench for audio_recorder (DIV=10, 2x8-bit frames, 8-frame buffer)
module tb_audio_recorder;

  localparam int FW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] mic_in = '0;
  logic          rec_start = 1'b0;
  logic          play_start = 1'b0;
  logic          stop = 1'b0;
  logic [FW-1:0] audio_out;
  logic          audio_valid;
  logic          busy;
  logic          done;
  logic [AW:0]   rec_len;
  logic [17:0]   ledr;

  always #5 clk = ~clk;

  audio_recorder #(
    .CLK_HZ(1000), .SAMPLE_RATE(100), .DATA_W(8), .CHANNELS(2), .DEPTH(8), .LED_W(18)
  ) dut (
    .clk(clk), .rst(rst), .mic_in(mic_in), .rec_start(rec_start), .play_start(play_start),
    .stop(stop), .audio_out(audio_out), .audio_valid(audio_valid), .busy(busy), .done(done),
    .rec_len(rec_len), .ledr(ledr)
  );

  typedef struct {
    logic [FW-1:0] frame;
    bit            chk_gap;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  int cyc = 0;
  int last_valid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every playback strobe and counts done pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (audio_valid) begin
          valid_cnt++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_frame: got 0x%0h, want no frame", audio_out);
          end else begin
            e = exp_q.pop_front();
            check("frame", audio_out, e.frame);
            if (e.chk_gap) check("frame_gap", cyc - last_valid, 10);
          end
          last_valid = cyc;
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic wait_done(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(posedge clk); #1;
      seen = done;
    end
    check("done_seen", seen, 1);
  endtask

  task automatic record(input int n, input logic [FW-1:0] base, input bit do_stop);
    @(posedge clk); #1 rec_start = 1'b1;
    @(posedge clk); #1 rec_start = 1'b0;
    check("rec_busy", busy, 1);
    for (int j = 0; j < n; j++) begin
      mic_in = base + FW'(j) * 16'h0101;
      repeat (9) @(posedge clk);
      #1;
      check("rec_len_pre_tick", rec_len, j);
      check("ledr_rec", ledr[2:0], 3'b001);
      @(posedge clk); #1;
      check("rec_len_post_tick", rec_len, j + 1);
    end
    if (do_stop) begin
      stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
    end
    check("rec_done", done, 1);
    @(posedge clk); #1;
    check("rec_done_1cyc", done, 0);
    check("rec_idle", busy, 0);
    check("rec_len_final", rec_len, n);
    check("ledr_full", ledr[2], (n == 8));
  endtask

  task automatic play(input int n, input logic [FW-1:0] base);
    int d0;
    d0 = done_cnt;
    for (int j = 0; j < n; j++) exp_q.push_back('{frame: base + FW'(j) * 16'h0101, chk_gap: (j != 0)});
    @(posedge clk); #1 play_start = 1'b1;
    @(posedge clk); #1 play_start = 1'b0;
    check("play_busy", busy, 1);
    @(posedge clk); #1;
    check("ledr_play", ledr[1:0], 2'b10);
    wait_done(10 * n + 20);
    @(posedge clk); #1;
    check("play_frames_left", exp_q.size(), 0);
    check("play_done_count", done_cnt - d0, 1);
    check("play_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int v0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_audio_out", audio_out, 0);
    check("rst_audio_valid", audio_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rec_len", rec_len, 0);
    check("rst_ledr", ledr, 0);
    rst = 1'b0;

    record(8, 16'h0000, 1'b0);
    play(8, 16'h0000);

    record(3, 16'h4040, 1'b1);
    play(3, 16'h4040);

    // rec_len is 3 here, so play_start alone would be honoured; record must win.
    @(posedge clk); #1 rec_start = 1'b1; play_start = 1'b1;
    @(posedge clk); #1 rec_start = 1'b0; play_start = 1'b0;
    check("both_busy", busy, 1);
    @(posedge clk); #1;
    check("both_ledr", ledr[1:0], 2'b01);
    d0 = done_cnt;
    repeat (39) @(posedge clk);
    #1;
    check("mid_rec_len", rec_len, 4);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rec_len", rec_len, 0);
    check("abort_ledr", ledr, 0);
    check("abort_done", done, 0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);

    v0 = valid_cnt;
    @(posedge clk); #1 play_start = 1'b1;
    @(posedge clk); #1 play_start = 1'b0;
    check("empty_play_busy", busy, 0);
    repeat (15) @(posedge clk);
    #1;
    check("empty_play_idle", busy, 0);
    check("empty_play_frames", valid_cnt - v0, 0);

`ifdef LOOP_PLAY_EN
    record(3, 16'h0000, 1'b1);
    d0 = done_cnt;
    for (int j = 0; j < 7; j++) exp_q.push_back('{frame: FW'(j % 3) * 16'h0101, chk_gap: (j != 0)});
    @(posedge clk); #1 play_start = 1'b1;
    @(posedge clk); #1 play_start = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("loop_frames_left", exp_q.size(), 0);
    check("loop_busy", busy, 1);
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    check("loop_done", done, 1);
    @(posedge clk); #1;
    check("loop_done_count", done_cnt - d0, 1);
    check("loop_idle", busy, 0);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
